// File: rtl/vl_uart_rxmon_pkg.sv
// Shared types and constants for the UART console monitor.
// State encoding, default TERM/EOL bytes, counter width.
package vl_uart_rxmon_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] TERM_DEF = 8'hFF;
  localparam logic [7:0] EOL_DEF  = 8'h0A;
  localparam int         CNT_W    = 16;

endpackage

// File: rtl/vl_sync_fifo.sv
// Synchronous FIFO with log2(DEPTH)+1 bit pointers.
// Ports: clk, rst, push/din, pop/dout, full, empty.
module vl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] P_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same cycle,
  // so a full FIFO may still take a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vl_uart_rxmon.sv
// Console monitor: buffers UART bytes, counts lines/drops, ends on TERM.
// Ports: clk, rst, data_in/data_wr, out_*, done, overflow, drop_cnt, line_cnt.
module vl_uart_rxmon
  import vl_uart_rxmon_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [7:0] TERM  = TERM_DEF,
  parameter logic [7:0] EOL   = EOL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_wr,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] line_cnt
);

  localparam logic [CNT_W-1:0] C_ONE = 1;

  state_t state;
  state_t state_nx;

  logic full;
  logic empty;
  logic pop;
  logic is_run;
  logic is_term;
  logic byte_wr;
  logic push;
  logic drop;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign is_run    = (state == ST_RUN);
  assign is_term   = (data_in == TERM);
  assign byte_wr   = is_run && data_wr && !is_term;
  assign push      = byte_wr && (!full || pop);
  assign drop      = byte_wr && full && !pop;
  assign done      = (state == ST_DONE);

  vl_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (data_in),
    .pop   (pop),
    .dout  (out_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  // An empty FIFO cannot pop, so empty alone ends DRAIN.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN:   if (data_wr && is_term) state_nx = ST_DRAIN;
      ST_DRAIN: if (empty)              state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      line_cnt <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + C_ONE;
      end
      if (push && data_in == EOL) line_cnt <= line_cnt + C_ONE;
    end
  end

endmodule
